// File: rtl/cache_refill_ctrl.sv
// Write-port sequencer for the 4-bank line data array: merges CPU store-hit writes and
// 4-beat line refills onto one registered write port.
module cache_refill_ctrl #(
    parameter int INDEX_AW  = 8,
    parameter int OFFSET_AW = 4,
    parameter int DATA_W    = 32,
    parameter int BEATS     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 miss_req_i,
    input  logic [31:0]          miss_addr_i,
    output logic                 miss_ready_o,
    output logic                 mem_req_o,
    output logic [31:0]          mem_addr_o,
    input  logic                 mem_ack_i,
    input  logic                 mem_rvalid_i,
    input  logic [DATA_W-1:0]    mem_rdata_i,
    input  logic                 st_req_i,
    input  logic [INDEX_AW-1:0]  st_index_i,
    input  logic [OFFSET_AW-1:0] st_offset_i,
    input  logic [3:0]           st_be_i,
    input  logic [DATA_W-1:0]    st_data_i,
    output logic                 st_ack_o,
    output logic [INDEX_AW-1:0]  index_o,
    output logic [OFFSET_AW-1:0] offset_o,
    output logic [3:0]           wr_en_o,
    output logic [DATA_W-1:0]    wr_data_o,
    output logic                 refill_done_o,
    output logic [1:0]           fsm_state
);

    // Handshakes: a request is a level held by the requester; it is consumed in the
    // cycle where the matching ack/ready is high (miss_ready_o, st_ack_o, mem_ack_i).
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] line_addr;
    logic [1:0]  beat_cnt;
    logic        beat_fire;
    logic        last_beat;

    assign beat_fire  = (state == FILL) && mem_rvalid_i;
    assign last_beat  = (beat_cnt == 2'(BEATS - 1));
    assign mem_addr_o = line_addr;
    assign fsm_state  = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        st_ack_o     = 1'b0;
        miss_ready_o = 1'b0;
        mem_req_o    = 1'b0;
        case (state)
            IDLE: begin
                // Stores take priority over a pending miss.
                st_ack_o     = st_req_i;
                miss_ready_o = miss_req_i & ~st_req_i;
                if (miss_req_i && !st_req_i) begin
                    state_nx = REQ;
                end
            end
            REQ: begin
                mem_req_o = 1'b1;
                if (mem_ack_i) begin
                    state_nx = FILL;
                end
            end
            FILL: begin
                if (beat_fire && last_beat) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                // DONE spans the bank-3 write cycle and the done-pulse cycle.
                if (refill_done_o) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_addr     <= '0;
            beat_cnt      <= '0;
            refill_done_o <= 1'b0;
        end else begin
            refill_done_o <= (state == DONE) && !refill_done_o;
            if (state == IDLE && miss_req_i && !st_req_i) begin
                line_addr <= miss_addr_i & ~32'hF;
            end
            if (state == REQ && mem_ack_i) begin
                beat_cnt <= '0;
            end else if (beat_fire) begin
                beat_cnt <= beat_cnt + 2'd1;
            end
        end
    end

    // Array write port: at most one write per cycle, one cycle after the accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index_o   <= '0;
            offset_o  <= '0;
            wr_en_o   <= '0;
            wr_data_o <= '0;
        end else begin
            wr_en_o <= '0;
            if (st_ack_o) begin
                index_o   <= st_index_i;
                offset_o  <= st_offset_i;
                wr_en_o   <= st_be_i;
                wr_data_o <= st_data_i;
            end else if (beat_fire) begin
                index_o   <= line_addr[OFFSET_AW +: INDEX_AW];
                offset_o  <= OFFSET_AW'({beat_cnt, 2'b00});
                wr_en_o   <= 4'hF;
                wr_data_o <= mem_rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Self-checking bench for cache_refill_ctrl: directed scenarios plus randomized refills and
// stores, checked against an expected-write queue built from the line/beat rules.
`timescale 1ns/1ps
module tb_cache_refill_ctrl;
    localparam int INDEX_AW  = 8;
    localparam int OFFSET_AW = 4;
    localparam int DATA_W    = 32;
    localparam int REC_W     = INDEX_AW + OFFSET_AW + 4 + DATA_W;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 miss_req_i;
    logic [31:0]          miss_addr_i;
    logic                 miss_ready_o;
    logic                 mem_req_o;
    logic [31:0]          mem_addr_o;
    logic                 mem_ack_i;
    logic                 mem_rvalid_i;
    logic [DATA_W-1:0]    mem_rdata_i;
    logic                 st_req_i;
    logic [INDEX_AW-1:0]  st_index_i;
    logic [OFFSET_AW-1:0] st_offset_i;
    logic [3:0]           st_be_i;
    logic [DATA_W-1:0]    st_data_i;
    logic                 st_ack_o;
    logic [INDEX_AW-1:0]  index_o;
    logic [OFFSET_AW-1:0] offset_o;
    logic [3:0]           wr_en_o;
    logic [DATA_W-1:0]    wr_data_o;
    logic                 refill_done_o;
    logic [1:0]           fsm_state;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int req_seen;
    int st_ack_seen;
    logic [31:0] seen_mem_addr;
    logic        mem_addr_moved;
    logic [31:0] beat_data [4];
    logic [REC_W-1:0] exp_q[$];
    logic [REC_W-1:0] obs_q[$];

    // ---------------- clock / reset / DUT ----------------
    always #5 clk = ~clk;

    cache_refill_ctrl #(.INDEX_AW(INDEX_AW), .OFFSET_AW(OFFSET_AW), .DATA_W(DATA_W), .BEATS(4)) dut (
        .clk(clk), .rst(rst),
        .miss_req_i(miss_req_i), .miss_addr_i(miss_addr_i), .miss_ready_o(miss_ready_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .st_req_i(st_req_i), .st_index_i(st_index_i), .st_offset_i(st_offset_i),
        .st_be_i(st_be_i), .st_data_i(st_data_i), .st_ack_o(st_ack_o),
        .index_o(index_o), .offset_o(offset_o), .wr_en_o(wr_en_o), .wr_data_o(wr_data_o),
        .refill_done_o(refill_done_o), .fsm_state(fsm_state)
    );

    // Monitor: every array write and done pulse seen on the port.
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en_o != 4'h0) obs_q.push_back({index_o, offset_o, wr_en_o, wr_data_o});
            if (refill_done_o) done_cnt++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic observe();
        @(negedge clk);
        if (mem_req_o) begin
            if (req_seen == 0) seen_mem_addr = mem_addr_o;
            else if (mem_addr_o !== seen_mem_addr) mem_addr_moved = 1'b1;
            req_seen++;
        end
        if (st_ack_o) st_ack_seen++;
    endtask

    task automatic push_refill(input logic [31:0] addr);
        for (int k = 0; k < 4; k++) exp_q.push_back({addr[11:4], 4'(k * 4), 4'hF, beat_data[k]});
    endtask

    // Called one cycle after the miss was accepted; returns cycles from last beat to done.
    task automatic drive_refill(input int ack_delay, input int gap_min, input int gap_max,
                                input bit rv_in_req, output int done_lag);
        req_seen = 0; st_ack_seen = 0; mem_addr_moved = 1'b0; done_lag = -1;
        for (int d = 0; d <= ack_delay; d++) begin
            mem_ack_i    = (d == ack_delay);
            mem_rvalid_i = rv_in_req && (d == 0);
            mem_rdata_i  = 32'hBAD0_0000 + 32'(d);
            observe();
            next_cycle();
        end
        mem_ack_i = 1'b0; mem_rvalid_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(gap_max, gap_min)) begin observe(); next_cycle(); end
            mem_rvalid_i = 1'b1; mem_rdata_i = beat_data[k];
            observe();
            next_cycle();
            mem_rvalid_i = 1'b0;
        end
        for (int w = 1; w <= 8; w++) begin
            observe();
            if (refill_done_o) begin done_lag = w; break; end
            next_cycle();
        end
    endtask

    task automatic accept_miss(input logic [31:0] addr);
        miss_addr_i = addr; miss_req_i = 1'b1;
        @(negedge clk);
        checks++;
        if (miss_ready_o !== 1'b1) begin errors++; $display("FAIL miss_accept: miss_ready_o=%b expected 1", miss_ready_o); end
        next_cycle();
        miss_req_i = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({mem_req_o, mem_addr_o, index_o, offset_o, wr_en_o, wr_data_o, refill_done_o, fsm_state} !== '0) begin
            errors++; $display("FAIL reset_outputs: mem_req=%b addr=%h idx=%h off=%h we=%h data=%h done=%b state=%0d expected all 0",
                mem_req_o, mem_addr_o, index_o, offset_o, wr_en_o, wr_data_o, refill_done_o, fsm_state);
        end
        rst = 1'b0;
        next_cycle();
        @(negedge clk);
        checks++;
        if (fsm_state !== 2'd0 || wr_en_o !== 4'h0) begin errors++; $display("FAIL reset_release: state=%0d we=%h expected 0/0", fsm_state, wr_en_o); end
        next_cycle();
    endtask

    task automatic test_reset_mid_fill();
        int d0;
        accept_miss(32'h0000_0F40);
        mem_ack_i = 1'b1; next_cycle(); mem_ack_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hAAAA_0001; next_cycle();
        mem_rdata_i = 32'hAAAA_0002; next_cycle();
        mem_rvalid_i = 1'b0;
        d0 = done_cnt;
        checks++;
        if (wr_en_o !== 4'hF || offset_o !== 4'h4) begin errors++; $display("FAIL pre_reset_write: we=%h off=%h expected f/4", wr_en_o, offset_o); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({wr_en_o, index_o, offset_o, wr_data_o} !== '0) begin errors++; $display("FAIL reset_mid_fill_port: we=%h idx=%h off=%h data=%h expected 0", wr_en_o, index_o, offset_o, wr_data_o); end
        checks++;
        if ({mem_req_o, mem_addr_o, refill_done_o, fsm_state} !== '0) begin errors++; $display("FAIL reset_mid_fill_ctrl: req=%b addr=%h done=%b state=%0d expected 0", mem_req_o, mem_addr_o, refill_done_o, fsm_state); end
        @(negedge clk);
        rst = 1'b0;
        miss_addr_i = 32'h0000_0120; miss_req_i = 1'b1; #1;
        checks++;
        if (miss_ready_o !== 1'b1) begin errors++; $display("FAIL post_reset_ready_hi: miss_ready_o=%b expected 1", miss_ready_o); end
        miss_req_i = 1'b0; #1;
        checks++;
        if (miss_ready_o !== 1'b0) begin errors++; $display("FAIL post_reset_ready_lo: miss_ready_o=%b expected 0", miss_ready_o); end
        repeat (4) next_cycle();
        checks++;
        if (done_cnt != d0 || fsm_state !== 2'd0) begin errors++; $display("FAIL post_reset_idle: done pulses=%0d state=%0d expected 0/0", done_cnt - d0, fsm_state); end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_refill_basic();
        int lag, d0;
        logic [REC_W-1:0] rec_e, rec_o;
        obs_q.delete(); exp_q.delete();
        beat_data = '{32'h11, 32'h22, 32'h33, 32'h44};
        push_refill(32'h0000_1A30);
        d0 = done_cnt;
        accept_miss(32'h0000_1A30);
        drive_refill(2, 0, 0, 1'b0, lag);
        next_cycle();
        checks++;
        if (req_seen != 3) begin errors++; $display("FAIL basic_mem_req_cycles: got %0d expected 3", req_seen); end
        checks++;
        if (seen_mem_addr !== 32'h0000_1A30 || mem_addr_moved) begin errors++; $display("FAIL basic_mem_addr: got %h moved=%b expected 00001a30 stable", seen_mem_addr, mem_addr_moved); end
        checks++;
        if (lag != 2 || done_cnt - d0 != 1) begin errors++; $display("FAIL basic_done: lag=%0d pulses=%0d expected 2/1", lag, done_cnt - d0); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_write_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            rec_e = exp_q.pop_front(); rec_o = obs_q.pop_front(); checks++;
            if (rec_o !== rec_e) begin errors++; $display("FAIL basic_write: got %h expected %h", rec_o, rec_e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_store();
        logic [7:0] idx; logic [3:0] off; logic [3:0] be; logic [31:0] data;
        for (int i = 0; i < 5; i++) begin
            if (i == 0) begin idx = 8'h05; off = 4'h8; be = 4'b0011; data = 32'hDEADBEEF; end
            else begin idx = 8'($urandom); off = 4'($urandom); be = 4'($urandom_range(15, 1)); data = $urandom; end
            st_index_i = idx; st_offset_i = off; st_be_i = be; st_data_i = data; st_req_i = 1'b1;
            @(negedge clk);
            checks++;
            if (st_ack_o !== 1'b1) begin errors++; $display("FAIL store_ack[%0d]: got %b expected 1", i, st_ack_o); end
            next_cycle();
            st_req_i = 1'b0; st_data_i = ~data;
            @(negedge clk);
            checks++;
            if ({index_o, offset_o, wr_en_o, wr_data_o} !== {idx, off, be, data})
                begin errors++; $display("FAIL store_write[%0d]: got %h/%h/%h/%h expected %h/%h/%h/%h", i, index_o, offset_o, wr_en_o, wr_data_o, idx, off, be, data); end
            next_cycle();
            @(negedge clk);
            checks++;
            if (wr_en_o !== 4'h0 || index_o !== idx || wr_data_o !== data)
                begin errors++; $display("FAIL store_hold[%0d]: we=%h idx=%h data=%h expected 0/%h/%h", i, wr_en_o, index_o, wr_data_o, idx, data); end
            next_cycle();
        end
        obs_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [REC_W-1:0] rec_e, rec_o;
        obs_q.delete(); exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            st_index_i = 8'($urandom); st_offset_i = 4'($urandom); st_be_i = 4'($urandom_range(15, 1));
            st_data_i = $urandom; st_req_i = 1'b1;
            exp_q.push_back({st_index_i, st_offset_i, st_be_i, st_data_i});
            @(negedge clk);
            checks++;
            if (st_ack_o !== 1'b1) begin errors++; $display("FAIL b2b_ack[%0d]: got %b expected 1", i, st_ack_o); end
            next_cycle();
        end
        st_req_i = 1'b0;
        next_cycle();
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_write_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            rec_e = exp_q.pop_front(); rec_o = obs_q.pop_front(); checks++;
            if (rec_o !== rec_e) begin errors++; $display("FAIL b2b_write: got %h expected %h", rec_o, rec_e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_priority();
        int lag;
        logic [31:0] addr;
        logic [REC_W-1:0] rec_e, rec_o;
        obs_q.delete(); exp_q.delete();
        addr = $urandom;
        for (int k = 0; k < 4; k++) beat_data[k] = $urandom;
        st_index_i = 8'($urandom); st_offset_i = 4'($urandom); st_be_i = 4'hF; st_data_i = $urandom;
        st_req_i = 1'b1; miss_req_i = 1'b1; miss_addr_i = addr;
        exp_q.push_back({st_index_i, st_offset_i, st_be_i, st_data_i});
        push_refill(addr);
        @(negedge clk);
        checks++;
        if (st_ack_o !== 1'b1 || miss_ready_o !== 1'b0) begin errors++; $display("FAIL prio_store_first: st_ack=%b miss_ready=%b expected 1/0", st_ack_o, miss_ready_o); end
        next_cycle();
        st_req_i = 1'b0;
        accept_miss(addr);
        drive_refill(1, 0, 1, 1'b0, lag);
        next_cycle();
        checks++;
        if (req_seen != 2 || seen_mem_addr !== {addr[31:4], 4'h0}) begin errors++; $display("FAIL prio_mem_req: cycles=%0d addr=%h expected 2/%h", req_seen, seen_mem_addr, {addr[31:4], 4'h0}); end
        checks++;
        if (lag != 2) begin errors++; $display("FAIL prio_done_lag: got %0d expected 2", lag); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL prio_write_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            rec_e = exp_q.pop_front(); rec_o = obs_q.pop_front(); checks++;
            if (rec_o !== rec_e) begin errors++; $display("FAIL prio_write: got %h expected %h", rec_o, rec_e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_store_during_fill();
        int lag;
        logic [REC_W-1:0] rec_e, rec_o;
        obs_q.delete(); exp_q.delete();
        for (int k = 0; k < 4; k++) beat_data[k] = $urandom;
        push_refill(32'h0000_0B70);
        accept_miss(32'h0000_0B70);
        st_index_i = 8'h3C; st_offset_i = 4'h6; st_be_i = 4'b1100; st_data_i = 32'hCAFE_F00D; st_req_i = 1'b1;
        exp_q.push_back({8'h3C, 4'h6, 4'b1100, 32'hCAFE_F00D});
        drive_refill(1, 1, 2, 1'b0, lag);
        checks++;
        if (st_ack_seen != 0 || lag != 2) begin errors++; $display("FAIL fill_store_stall: acks=%0d lag=%0d expected 0/2", st_ack_seen, lag); end
        next_cycle();
        @(negedge clk);
        checks++;
        if (st_ack_o !== 1'b1) begin errors++; $display("FAIL fill_store_ack_after_done: got %b expected 1", st_ack_o); end
        next_cycle();
        st_req_i = 1'b0;
        next_cycle();
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL fill_store_write_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            rec_e = exp_q.pop_front(); rec_o = obs_q.pop_front(); checks++;
            if (rec_o !== rec_e) begin errors++; $display("FAIL fill_store_write: got %h expected %h", rec_o, rec_e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_random_refills(input int n, input int gap_min, input int gap_max, input bit force_rv);
        int lag, dly, d0;
        logic [31:0] addr;
        logic [REC_W-1:0] rec_e, rec_o;
        for (int it = 0; it < n; it++) begin
            obs_q.delete(); exp_q.delete();
            addr = $urandom;
            dly = $urandom_range(3, 0);
            for (int k = 0; k < 4; k++) beat_data[k] = $urandom;
            push_refill(addr);
            d0 = done_cnt;
            accept_miss(addr);
            drive_refill(dly, gap_min, gap_max, force_rv || ($urandom_range(1, 0) == 1), lag);
            next_cycle();
            checks++;
            if (req_seen != dly + 1 || mem_addr_moved || seen_mem_addr !== {addr[31:4], 4'h0})
                begin errors++; $display("FAIL rand_mem_req[%0d]: cycles=%0d addr=%h moved=%b expected %0d/%h/0", it, req_seen, seen_mem_addr, mem_addr_moved, dly + 1, {addr[31:4], 4'h0}); end
            checks++;
            if (lag != 2 || done_cnt - d0 != 1) begin errors++; $display("FAIL rand_done[%0d]: lag=%0d pulses=%0d expected 2/1", it, lag, done_cnt - d0); end
            checks++;
            if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_write_count[%0d]: got %0d expected %0d", it, obs_q.size(), exp_q.size()); end
            while (exp_q.size() > 0 && obs_q.size() > 0) begin
                rec_e = exp_q.pop_front(); rec_o = obs_q.pop_front(); checks++;
                if (rec_o !== rec_e) begin errors++; $display("FAIL rand_write[%0d]: got %h expected %h", it, rec_o, rec_e); end
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1;
        miss_req_i = 1'b0; miss_addr_i = '0; mem_ack_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        st_req_i = 1'b0; st_index_i = '0; st_offset_i = '0; st_be_i = '0; st_data_i = '0;
        repeat (2) @(posedge clk);
        test_reset();
        test_refill_basic();
        test_store();
        test_back_to_back();
        test_priority();
        test_store_during_fill();
        test_random_refills(1, 3, 3, 1'b1);
        test_reset_mid_fill();
        test_random_refills(6, 0, 2, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
